dt_stat: RTL
============

DT_STAT -- requirements
Module: dt_stat

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  one-cycle pulse, driven by the distance-transform stage's done; begins a scan.
REQ-004 SHALL have port: res_rd  output  1  read strobe to the 128x128 result RAM.
REQ-005 SHALL have port: res_addr  output  14  result RAM address, row-major, row = addr[13:7], col = addr[6:0].
REQ-006 SHALL have port: res_di  input  8  result RAM read data, valid at the posedge following the address cycle.
REQ-007 SHALL have port: busy  output  1  high from the cycle after start is accepted until valid.
REQ-008 SHALL have port: valid  output  1  one-cycle pulse; results are final.
REQ-009 SHALL have port: max_val  output  8  largest distance value in the image.
REQ-010 SHALL have port: max_addr  output  14  lowest address holding max_val.
REQ-011 SHALL have port: fg_count  output  15  number of pixels with value != 0.

Function
REQ-012 SHALL implement FSM IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
REQ-013 SHALL leave IDLE for SCAN only on start=1 sampled in IDLE; start in any other state SHALL be ignored.
REQ-014 SHALL, in SCAN, assert res_rd=1 and drive res_addr 0,1,...,16383 on consecutive cycles, one address per cycle, for 16384 cycles.
REQ-015 SHALL enter DRAIN after address 16383, holding res_rd=0 for one cycle while the last datum is sampled.
REQ-016 SHALL, in DONE, pulse valid for exactly one cycle and then return to IDLE.
REQ-017 SHALL assert valid exactly 16386 cycles after the edge that samples start.
REQ-018 SHALL hold res_addr at 0 and res_rd at 0 outside SCAN.
REQ-019 SHALL pair each sampled res_di with the address of the previous cycle through a one-stage delayed address register.
REQ-020 SHALL update max_val/max_addr only on strictly greater data, so that ties keep the lowest address.
REQ-021 SHALL increment fg_count for every sampled res_di != 0, with no saturation (maximum 16384 fits in 15 bits).
REQ-022 SHALL clear max_val, max_addr and fg_count to 0 on the cycle start is accepted.
REQ-023 SHALL hold max_val, max_addr and fg_count stable from valid until the next accepted start.
REQ-024 SHALL report max_val=0, max_addr=0 and fg_count=0 for an all-zero image.

Reset
REQ-025 SHALL, on reset=0 at any time, including mid-scan, force state IDLE and set res_rd=0, res_addr=0, busy=0, valid=0, max_val=0, max_addr=0 and fg_count=0 immediately.
REQ-026 SHALL require a new start after reset release; an interrupted scan SHALL NOT resume.

Configuration
REQ-027 SHALL, with macro DT_STAT_THRESH_EN defined, add input thresh[7:0] and output thresh_count[14:0].
REQ-028 SHALL, with DT_STAT_THRESH_EN defined, latch thresh at start acceptance and count sampled pixels with value >= latched thresh; thresh_count SHALL follow the reset, clear and hold rules of fg_count.
REQ-029 SHALL, with DT_STAT_THRESH_EN undefined, omit both ports and all related logic, with all other behaviour identical.

Structure
REQ-030 SHALL take IMG_W=128, ADDR_W=14, DATA_W=8, CNT_W=15 and the FSM state enum from shared package dt_pkg.
REQ-031 SHALL place the compare/count datapath (max, argmax, fg and threshold counters) in sub-module dt_stat_acc; dt_stat holds the FSM and address generation.

Verification
REQ-032 SHALL test: all-zero image, start pulse -> valid at start edge + 16386 cycles; max_val=0, max_addr=0, fg_count=0.
REQ-033 SHALL test: single pixel value 5 at addr 8321, all others 0 -> max_val=5, max_addr=8321, fg_count=1.
REQ-034 SHALL test: value 9 at addr 300 and at addr 12000 -> max_addr=300 (tie rule).
REQ-035 SHALL test: pixel 16383=200, all others 1 -> max_val=200, max_addr=16383, fg_count=16384 (last pixel captured in DRAIN).
REQ-036 SHALL test: reset=0 at scan cycle 5000, then release and start -> outputs 0 immediately; the fresh scan reports results identical to an uninterrupted run; start pulses during busy are ignored.
REQ-037 SHALL test, with DT_STAT_THRESH_EN defined: thresh=3 on an image holding values 0..7, 100 pixels each -> thresh_count=500.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared sizes and FSM state type for the distance-transform statistics scanner.
package dt_pkg;

   localparam int unsigned IMG_W   = 128;
   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned CNT_W   = 15;
   localparam int unsigned NUM_PIX = IMG_W * IMG_W;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDrain,
      StDone
   } dt_state_e;

endpackage

// File: rtl/dt_stat_if.sv
// Result-RAM read port: the scanner is master, the RAM is slave.
interface dt_stat_if;
   import dt_pkg::*;

   logic              res_rd;
   logic [ADDR_W-1:0] res_addr;
   logic [DATA_W-1:0] res_di;

   modport master (output res_rd, output res_addr, input res_di);
   modport slave  (input res_rd, input res_addr, output res_di);

endinterface

// File: rtl/dt_stat_acc.sv
// Compare/count datapath: max, argmax, foreground count and, with DT_STAT_THRESH_EN,
// a threshold count. Pairs each RAM datum with the address issued one cycle earlier.
module dt_stat_acc
   import dt_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              rd,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] di,
   output logic [DATA_W-1:0] max_val,
   output logic [ADDR_W-1:0] max_addr,
   output logic [CNT_W-1:0]  fg_count
`ifdef DT_STAT_THRESH_EN
   ,
   input  logic [DATA_W-1:0] thresh,
   output logic [CNT_W-1:0]  thresh_count
`endif
);

   logic              smp_q;
   logic [ADDR_W-1:0] smp_addr_q;
   logic [DATA_W-1:0] max_q;
   logic [ADDR_W-1:0] arg_q;
   logic [CNT_W-1:0]  fg_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         smp_q      <= 1'b0;
         smp_addr_q <= '0;
         max_q      <= '0;
         arg_q      <= '0;
         fg_q       <= '0;
      end else begin
         smp_q      <= rd;
         smp_addr_q <= addr;
         if (clear) begin
            max_q <= '0;
            arg_q <= '0;
            fg_q  <= '0;
         end else if (smp_q) begin
            // Strictly greater keeps the lowest address on ties.
            if (di > max_q) begin
               max_q <= di;
               arg_q <= smp_addr_q;
            end
            if (di != '0) begin
               fg_q <= fg_q + CNT_W'(1);
            end
         end
      end
   end

   assign max_val  = max_q;
   assign max_addr = arg_q;
   assign fg_count = fg_q;

`ifdef DT_STAT_THRESH_EN
   logic [DATA_W-1:0] thr_q;
   logic [CNT_W-1:0]  tc_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         thr_q <= '0;
         tc_q  <= '0;
      end else if (clear) begin
         thr_q <= thresh;
         tc_q  <= '0;
      end else if (smp_q && (di >= thr_q)) begin
         tc_q <= tc_q + CNT_W'(1);
      end
   end

   assign thresh_count = tc_q;
`endif

endmodule

// File: rtl/dt_stat.sv
// Scans the 128x128 distance-transform result RAM once per start and reports max, argmax
// and foreground count. Define DT_STAT_THRESH_EN to add the thresh/thresh_count feature.
module dt_stat
   import dt_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   dt_stat_if.master         ram,
   output logic              busy,
   output logic              valid,
   output logic [DATA_W-1:0] max_val,
   output logic [ADDR_W-1:0] max_addr,
   output logic [CNT_W-1:0]  fg_count
`ifdef DT_STAT_THRESH_EN
   ,
   input  logic [DATA_W-1:0] thresh,
   output logic [CNT_W-1:0]  thresh_count
`endif
);

   localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(NUM_PIX - 1);

   dt_state_e         state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rd_q;
   logic              busy_q;
   logic              valid_q;
   logic              accept;

   assign accept = (state_q == StIdle) && start;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               valid_q <= 1'b0;
               if (start) begin
                  state_q <= StScan;
                  addr_q  <= '0;
                  rd_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            StScan: begin
               if (addr_q == AddrLast) begin
                  state_q <= StDrain;
                  addr_q  <= '0;
                  rd_q    <= 1'b0;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
            // Last datum is sampled at the end of this cycle, so valid is raised here.
            StDrain: begin
               state_q <= StDone;
               valid_q <= 1'b1;
            end
            StDone: begin
               state_q <= StIdle;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               addr_q  <= '0;
               rd_q    <= 1'b0;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign ram.res_rd   = rd_q;
   assign ram.res_addr = addr_q;
   assign busy         = busy_q;
   assign valid        = valid_q;

   dt_stat_acc u_acc (
      .clk          (clk),
      .reset        (reset),
      .clear        (accept),
      .rd           (rd_q),
      .addr         (addr_q),
      .di           (ram.res_di),
      .max_val      (max_val),
      .max_addr     (max_addr),
      .fg_count     (fg_count)
`ifdef DT_STAT_THRESH_EN
      ,
      .thresh       (thresh),
      .thresh_count (thresh_count)
`endif
   );

endmodule
